muldiv_unit: RTL

//  Iterative multiply/divide execution unit downstream of the 8x16 register file.
//  - Takes two operands from read ports A/B and computes MUL, MULH, DIV or REM over WIDTH cycles.
//  - Returns the result on a write-back triple (wb_en, wb_rc, wb_data) that drives the regfile write port.
//  - Control stalls issue while busy is high.

---
 rtl/muldiv_unit_if.sv | 27 ++
 rtl/muldiv_unit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
// Issue / write-back bundle between the regfile-side control and muldiv_unit.
// master: control side (drives issue); slave: the execution unit.
interface muldiv_unit_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
);
    logic              start;
    logic [1:0]        op;
    logic [ADDR_W-1:0] rd;
    logic [WIDTH-1:0]  opa;
    logic [WIDTH-1:0]  opb;
    logic              ready;
    logic              busy;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_rc;
    logic [WIDTH-1:0]  wb_data;

    modport master (
        output start, op, rd, opa, opb,
        input  ready, busy, wb_en, wb_rc, wb_data
    );

    modport slave (
        input  start, op, rd, opa, opb,
        output ready, busy, wb_en, wb_rc, wb_data
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: MUL, MULH, DIV, REM in WIDTH steps, one
// write-back strobe per operation. Optional two's complement support is
// enabled with the MULDIV_SIGNED_EN macro (operate on magnitudes, fix signs
// when leaving RUN).
module muldiv_unit #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
) (
    input  logic          clk,
    input  logic          resetn,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] rd_q;
    logic [WIDTH-1:0]  mc;      // multiplicand (MUL) or divisor (DIV)
    logic [WIDTH-1:0]  hi;      // product high half / partial remainder
    logic [WIDTH-1:0]  lo;      // multiplier bits / dividend -> quotient bits
    logic [CW-1:0]     cnt;
`ifdef MULDIV_SIGNED_EN
    logic              neg_q;   // product / quotient must be negated
    logic              rneg_q;  // remainder takes the dividend's sign
    logic              dz_q;    // divisor was zero
`endif

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     rsh;
    logic               ge;
    logic [WIDTH-1:0]   hi_n, lo_n;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, res;
    logic [WIDTH-1:0]   mc_i, lo_i;

    // Operand set-up at issue: multiplicand/divisor into mc, the other into lo
    always_comb begin
`ifdef MULDIV_SIGNED_EN
        logic [WIDTH-1:0] ma, mb;
        ma = bus.opa[WIDTH-1] ? -bus.opa : bus.opa;
        mb = bus.opb[WIDTH-1] ? -bus.opb : bus.opb;
        mc_i = bus.op[1] ? mb : ma;
        lo_i = bus.op[1] ? ma : mb;
`else
        mc_i = bus.op[1] ? bus.opb : bus.opa;
        lo_i = bus.op[1] ? bus.opa : bus.opb;
`endif
    end

    // One iteration: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        sum  = '0;
        rsh  = '0;
        ge   = 1'b0;
        hi_n = hi;
        lo_n = lo;
        if (!op_q[1]) begin
            sum  = {1'b0, hi} + (lo[0] ? {1'b0, mc} : '0);
            hi_n = sum[WIDTH:1];
            lo_n = {sum[0], lo[WIDTH-1:1]};
        end else begin
            rsh  = {hi, lo[WIDTH-1]};
            ge   = (rsh >= {1'b0, mc});
            if (ge) rsh = rsh - {1'b0, mc};
            hi_n = rsh[WIDTH-1:0];
            lo_n = {lo[WIDTH-2:0], ge};
        end
    end

    // Result select on the final step, including sign fix-up when enabled
    always_comb begin
`ifdef MULDIV_SIGNED_EN
        prod = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
        quo  = dz_q ? '1 : (neg_q ? -lo_n : lo_n);
        rem  = rneg_q ? -hi_n : hi_n;
`else
        prod = {hi_n, lo_n};
        quo  = lo_n;
        rem  = hi_n;
`endif
        case (op_q)
            2'b00:   res = prod[WIDTH-1:0];
            2'b01:   res = prod[2*WIDTH-1:WIDTH];
            2'b10:   res = quo;
            default: res = rem;
        endcase
    end

    // Control FSM and datapath registers; all outputs registered
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            bus.ready   <= 1'b1;
            bus.busy    <= 1'b0;
            bus.wb_en   <= 1'b0;
            bus.wb_rc   <= '0;
            bus.wb_data <= '0;
            cnt         <= '0;
            op_q        <= '0;
            rd_q        <= '0;
            mc          <= '0;
            hi          <= '0;
            lo          <= '0;
`ifdef MULDIV_SIGNED_EN
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            dz_q        <= 1'b0;
`endif
        end else begin
            case (state)
                RUN: begin
                    hi  <= hi_n;
                    lo  <= lo_n;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state       <= DONE;
                        bus.busy    <= 1'b0;
                        bus.ready   <= 1'b1;
                        bus.wb_en   <= 1'b1;
                        bus.wb_rc   <= rd_q;
                        bus.wb_data <= res;
                    end
                end
                default: begin  // IDLE or DONE: both accept a new issue
                    bus.wb_en <= 1'b0;
                    if (bus.start) begin
                        state     <= RUN;
                        bus.busy  <= 1'b1;
                        bus.ready <= 1'b0;
                        cnt       <= '0;
                        op_q      <= bus.op;
                        rd_q      <= bus.rd;
                        mc        <= mc_i;
                        lo        <= lo_i;
                        hi        <= '0;
`ifdef MULDIV_SIGNED_EN
                        neg_q     <= bus.opa[WIDTH-1] ^ bus.opb[WIDTH-1];
                        rneg_q    <= bus.opa[WIDTH-1];
                        dz_q      <= (bus.opb == '0);
`endif
                    end else begin
                        state     <= IDLE;
                        bus.ready <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule
